// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S playback transmitter.
// Samples are carried MSB-justified in a 24-bit field regardless of SAMPLE_W.
package i2s_pkg;

   localparam int SLOT_BITS    = 32;
   localparam int FRAME_BITS   = 64;
   localparam int MAX_SAMPLE_W = 24;

   typedef logic [5:0] bit_cnt_t;

   typedef struct packed {
      logic [MAX_SAMPLE_W-1:0] left;
      logic [MAX_SAMPLE_W-1:0] right;
   } stereo_t;

   // Slot layout: one leading zero (I2S one-bit delay), sample MSB first, zero pad.
   function automatic logic [FRAME_BITS-1:0] build_frame(input stereo_t s);
      return {1'b0, s.left,  {(SLOT_BITS-1-MAX_SAMPLE_W){1'b0}},
              1'b0, s.right, {(SLOT_BITS-1-MAX_SAMPLE_W){1'b0}}};
   endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider: toggles the bit-clock phase every CLK_DIV clk cycles and
// emits one-cycle strobes in the cycle before BCLK rises or falls.
module i2s_clk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic enable_i,
   output logic bclk_rise_o,
   output logic bclk_fall_o
);

   localparam int DW = $clog2(CLK_DIV + 1);

   logic [DW-1:0] div_q;
   logic          bclk_q;
   logic          tc;

   assign tc = enable_i && (div_q == DW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || !enable_i) begin
         div_q  <= '0;
         bclk_q <= 1'b0;
      end else if (tc) begin
         div_q  <= '0;
         bclk_q <= ~bclk_q;
      end else begin
         div_q  <= div_q + 1'b1;
      end
   end

   assign bclk_rise_o = tc && !bclk_q;
   assign bclk_fall_o = tc &&  bclk_q;

endmodule

// File: rtl/i2s_playback_tx.sv
// I2S playback transmitter: one-entry holding register feeding a 64-bit frame
// shifter; data and LR clock change only on BCLK falling edges.
module i2s_playback_tx
   import i2s_pkg::*;
#(
   parameter int CLK_DIV  = 2,
   parameter int SAMPLE_W = 24
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_left,
   input  logic [SAMPLE_W-1:0] s_right,
   output logic                ac_bclk,
   output logic                ac_pblrc,
   output logic                ac_reclrc,
   output logic                ac_sdata_o,
   output logic                ac_mute_n,
   output logic                underrun
);

   localparam int PAD = MAX_SAMPLE_W - SAMPLE_W;

   logic bclk_rise, bclk_fall;

   i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk         (clk),
      .rst         (rst),
      .enable_i    (enable),
      .bclk_rise_o (bclk_rise),
      .bclk_fall_o (bclk_fall)
   );

   bit_cnt_t              b_q, b_next;
   stereo_t               hold_q, s_in;
   logic                  hold_vld_q, hold_vld_d;
   logic [FRAME_BITS-1:0] shift_q;
   logic                  bclk_q, lrc_q, sdata_q, mute_q, ready_q, urun_q;
   logic                  accept, load;

   assign s_in.left  = MAX_SAMPLE_W'(s_left)  << PAD;
   assign s_in.right = MAX_SAMPLE_W'(s_right) << PAD;

   assign accept     = s_valid && ready_q;
   assign load       = bclk_fall && (b_q == bit_cnt_t'(FRAME_BITS - 1));
   assign b_next     = b_q + 1'b1;
   // Load consumes the pre-accept contents; an accept in that cycle refills.
   assign hold_vld_d = (hold_vld_q && !load) || accept;

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         b_q        <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         shift_q    <= '0;
         bclk_q     <= 1'b0;
         lrc_q      <= 1'b0;
         sdata_q    <= 1'b0;
         mute_q     <= 1'b0;
         ready_q    <= 1'b0;
         urun_q     <= 1'b0;
      end else begin
         mute_q     <= 1'b1;
         ready_q    <= !hold_vld_d;
         hold_vld_q <= hold_vld_d;
         urun_q     <= load && !hold_vld_q;
         if (accept)
            hold_q <= s_in;
         if (bclk_rise)
            bclk_q <= 1'b1;
         if (bclk_fall) begin
            bclk_q <= 1'b0;
            b_q    <= b_next;
            lrc_q  <= b_next[5];
            if (load) begin
               shift_q <= hold_vld_q ? build_frame(hold_q) : '0;
               sdata_q <= 1'b0;
            end else begin
               shift_q <= shift_q << 1;
               sdata_q <= shift_q[FRAME_BITS-2];
            end
         end
      end
   end

   assign s_ready    = ready_q;
   assign ac_bclk    = bclk_q;
   assign ac_pblrc   = lrc_q;
   assign ac_reclrc  = lrc_q;
   assign ac_sdata_o = sdata_q;
   assign ac_mute_n  = mute_q;
   assign underrun   = urun_q;

endmodule

// File: doc/i2s_playback_tx.md
I2S_PLAYBACK_TX -- requirements
Module: i2s_playback_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk cycles per BCLK half-period, range 1..255.
REQ-002 SHALL have parameter SAMPLE_W, default 24: audio sample width, range 16..24, MSB-justified in a 32-bit slot.
REQ-003 SHALL have a single clock domain; reset synchronous, active-high.
REQ-004 clk  in  1  system clock; 12.288 MHz nominal (BCLK 3.072 MHz, 48 kHz at CLK_DIV=2).
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 enable  in  1  playback enable; 0 = silence, mute, halt clocks.
REQ-007 s_valid  in  1  stereo sample offered.
REQ-008 s_ready  out  1  holding register empty and enable=1.
REQ-009 s_left  in  SAMPLE_W  left sample, two's complement.
REQ-010 s_right  in  SAMPLE_W  right sample, two's complement.
REQ-011 ac_bclk  out  1  codec bit clock.
REQ-012 ac_pblrc  out  1  playback LR clock; 0 = left.
REQ-013 ac_reclrc  out  1  record LR clock, identical copy of ac_pblrc.
REQ-014 ac_sdata_o  out  1  serial playback data.
REQ-015 ac_mute_n  out  1  codec mute, active-low.
REQ-016 underrun  out  1  one-cycle pulse: frame started with no sample.

Function
REQ-017 Divider SHALL count 0..CLK_DIV-1 while enable=1; at terminal count ac_bclk toggles; BCLK period = 2*CLK_DIV clk.
REQ-018 Bit counter b (0..63) SHALL advance on each clk cycle where ac_bclk goes 1->0, wrapping 63->0.
REQ-019 ac_pblrc SHALL be 0 for b in 0..31 and 1 for b in 32..63, updated in the same cycle as b.
REQ-020 Within slot position p = b mod 32: p=0 drives 0; p=1..SAMPLE_W drives sample bit SAMPLE_W-p (MSB first); remaining positions drive 0.
REQ-021 ac_sdata_o SHALL change only in the cycle of a BCLK falling edge; stable across the rising edge (codec samples on rise).
REQ-022 Accept SHALL occur when s_valid & s_ready; sample stored in a one-entry holding register.
REQ-023 On the falling edge taking b 63->0 (frame load), the holding register SHALL move to the shift register and empty; if empty, shift register loads zeros and underrun pulses that cycle.
REQ-024 Frame load SHALL use holding contents before that cycle's accept; a sample accepted in the load cycle plays in the following frame.
REQ-025 The first frame after reset or enable rise SHALL be silent and SHALL NOT pulse underrun.
REQ-026 Throughput SHALL be one accept per 64 BCLK; no sample dropped or reordered while s_valid is held.
REQ-027 ac_mute_n SHALL equal registered enable.
REQ-028 enable 1->0 SHALL, next cycle: ac_bclk=0, ac_pblrc=0, ac_sdata_o=0, ac_mute_n=0, b=0, divider=0, holding flushed, s_ready=0; mid-frame abort permitted.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 After rst: ac_bclk=0, ac_pblrc=0, ac_reclrc=0, ac_sdata_o=0, ac_mute_n=0, underrun=0, s_ready=0, b=0, divider=0, holding empty, shift register zero.
REQ-031 rst mid-frame SHALL override all activity in the following cycle; no partial sample retained.

Structure
REQ-032 Package i2s_pkg SHALL hold SLOT_BITS=32, FRAME_BITS=64, bit-counter typedef and stereo-sample struct typedef.
REQ-033 Sub-module i2s_clk_gen SHALL implement divider and BCLK, emitting bclk_rise/bclk_fall strobes; remaining logic in i2s_playback_tx.

Verification
REQ-034 CLK_DIV=2, enable=1, stream L=24'hA5A5A5 R=24'h3C3C3C -> BCLK period 4 clk, pblrc period 256 clk, decoded left/right equal inputs from second frame on.
REQ-035 enable=1, s_valid=0 -> underrun pulses once per 256 clk (from second frame on), ac_sdata_o constant 0.
REQ-036 s_valid held high, incrementing samples 0..15 -> exactly one accept per 256 clk, decoded order 0..15, no gaps, no underrun.
REQ-037 rst asserted at b=40 -> next cycle all outputs at REQ-030 values; after release, first frame silent, then pending-free restart at b=0.
REQ-038 enable dropped at b=20 -> next cycle ac_mute_n=0, ac_bclk=0, s_ready=0; re-enable -> pblrc low for 128 clk, silent first frame, no underrun pulse.
REQ-039 Holding empty, s_valid rises in frame-load cycle -> underrun pulses, that frame silent, sample plays in next frame.
